// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory that answers lsu loads/stores with
// an optional fixed number of wait states per access.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-low reset
//   mem_read_en      load request
//   mem_write_en     store request
//   mem_addr         byte address
//   store_size       00 byte, 01 half, 10 word, 11 reserved
//   store_data       right-aligned store value
//   mem_wb_load_data aligned word read, registered (1-cycle latency)
//   mem_stall        combinational pipeline hold request
//   mem_err          registered one-cycle error flag for the completed access
//
// FSM states:
//   state | meaning
//   IDLE  | no access in flight; with WAIT_STATES=0 accesses complete here
//   WAIT  | counting down stall cycles; access completes when cnt reaches 0
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  output logic [31:0] mem_wb_load_data,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          do_access;
  logic          range_err;
  logic          align_err;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [AW-1:0] idx;

  assign req = mem_read_en | mem_write_en;
  assign idx = mem_addr[AW+1:2];

  always_comb begin
    range_err = ({2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS));
    align_err = 1'b0;
    if (mem_write_en && !mem_read_en) begin
      case (store_size)
        2'b00:   align_err = 1'b0;
        2'b01:   align_err = mem_addr[0];
        2'b10:   align_err = (mem_addr[1:0] != 2'b00);
        default: align_err = 1'b1;
      endcase
    end else if (mem_read_en) begin
      // loads are always full-word accesses; store_size is irrelevant
      align_err = (mem_addr[1:0] != 2'b00);
    end
    acc_err = range_err | align_err | (mem_read_en & mem_write_en);
  end

  // Replicating the sub-word across the bus puts it in every lane; the byte
  // enables then pick the lane(s) it actually lands in.
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (store_size)
      2'b00: begin
        be    = 4'b0001 << mem_addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    do_access = 1'b0;
    mem_stall = 1'b0;
    if (rst) begin
      if (state == ST_IDLE) begin
        do_access = req && (WAIT_STATES == 0);
        mem_stall = req && (WAIT_STATES != 0);
      end else begin
        do_access = (cnt == 4'd0);
        mem_stall = (cnt != 4'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      cnt              <= 4'd0;
      mem_wb_load_data <= 32'd0;
      mem_err          <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && (WAIT_STATES != 0)) begin
            state <= ST_WAIT;
            cnt   <= 4'(WAIT_STATES - 1);
          end
        end
        default: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
      endcase
      if (do_access) begin
        if (acc_err) begin
          mem_wb_load_data <= 32'd0;
          mem_err          <= 1'b1;
        end else if (mem_read_en) begin
          mem_wb_load_data <= mem[idx];
        end
      end
    end
  end

  // Memory contents survive reset; do_access is already gated by rst.
  always_ff @(posedge clk) begin
    if (do_access && mem_write_en && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS0   = 0;
  localparam int WS1   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [1:0]  size  [2];
  logic [31:0] sdata [2];
  logic [31:0] ld    [2];
  logic        stall [2];
  logic        err   [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst(rst_n[0]), .mem_read_en(rd[0]), .mem_write_en(wr[0]),
    .mem_addr(addr[0]), .store_size(size[0]), .store_data(sdata[0]),
    .mem_wb_load_data(ld[0]), .mem_stall(stall[0]), .mem_err(err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst(rst_n[1]), .mem_read_en(rd[1]), .mem_write_en(wr[1]),
    .mem_addr(addr[1]), .store_size(size[1]), .store_data(sdata[1]),
    .mem_wb_load_data(ld[1]), .mem_stall(stall[1]), .mem_err(err[1]));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // reference model: byte-addressed little-endian memory per instance
  logic [7:0]  ref_b  [2][DEPTH*4];
  logic [31:0] last_ld[2];
  logic [31:0] init_w [2][DEPTH];
  bit          pending[2];

  function automatic int ws_of(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(int d, bit r, bit w, logic [31:0] a, logic [1:0] sz, logic [31:0] dat);
    exp_t e;
    bit   bad = 0;
    int   nb  = 4;
    if (r && w) bad = 1;
    else if (r) bad = (a % 4 != 0) || ((a >> 2) >= 32'(DEPTH));
    else begin
      if (sz == 2'd3) bad = 1;
      else begin
        nb  = 1 << sz;
        bad = (a % nb != 0) || ((a >> 2) >= 32'(DEPTH));
      end
    end
    if (bad) begin
      last_ld[d] = 32'd0;
      e.err = 1'b1;
    end else if (r) begin
      last_ld[d] = {ref_b[d][a+3], ref_b[d][a+2], ref_b[d][a+1], ref_b[d][a]};
      e.err = 1'b0;
    end else begin
      for (int k = 0; k < nb; k++) ref_b[d][a+k] = dat[8*k +: 8];
      e.err = 1'b0;
    end
    e.data = last_ld[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the access edge.
  task automatic access(int d, bit r, bit w, logic [31:0] a, logic [1:0] sz, logic [31:0] dat);
    int n    = 0;
    bit done = 0;
    rd[d] = r; wr[d] = w; addr[d] = a; size[d] = sz; sdata[d] = dat;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall[d]) begin
        n++;
        @(posedge clk); #1;
      end else begin
        model(d, r, w, a, sz, dat);
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stall_timeout[%0d]: got >40 stall cycles expected %0d", d, ws_of(d));
    end else if (n != ws_of(d)) begin
      errors++;
      $display("FAIL stall_count[%0d]: got %0d expected %0d", d, n, ws_of(d));
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic lit(int d, string name, logic [31:0] data, logic e);
    @(negedge clk);
    check($sformatf("%s_data[%0d]", name, d), ld[d], data);
    check($sformatf("%s_err[%0d]", name, d), {31'd0, err[d]}, {31'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic mon(int d);
    exp_t e;
    if (pending[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL sb_empty[%0d]: got response expected none queued", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("sb_data[%0d]", d), ld[d], e.data);
        check($sformatf("sb_err[%0d]", d), {31'd0, err[d]}, {31'd0, e.err});
      end
    end else if (rst_n[d]) begin
      check($sformatf("err_idle[%0d]", d), {31'd0, err[d]}, 32'd0);
    end
    pending[d] = rst_n[d] && (rd[d] || wr[d]) && !stall[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = 32'd0; size[d] = 2'd0; sdata[d] = 32'd0;
      last_ld[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_data[%0d]", d), ld[d], 32'd0);
      check($sformatf("rst_err[%0d]", d), {31'd0, err[d]}, 32'd0);
      check($sformatf("rst_stall[%0d]", d), {31'd0, stall[d]}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // fill memories with known random words
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) begin
        init_w[d][w] = $urandom;
        access(d, 0, 1, 32'(w*4), 2'd2, init_w[d][w]);
      end

    // directed cases on both wait-state configurations
    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1, 32'h8, 2'd2, 32'h11223344);
      access(d, 1, 0, 32'h8, 2'd0, 32'h0);
      lit(d, "lw8", 32'h11223344, 1'b0);
      access(d, 0, 1, 32'h9, 2'd0, 32'h000000AA);
      access(d, 1, 0, 32'h8, 2'd2, 32'h0);
      lit(d, "sb9", 32'h1122AA44, 1'b0);
      access(d, 0, 1, 32'hA, 2'd1, 32'h0000BEEF);
      access(d, 1, 0, 32'h8, 2'd3, 32'h0);
      lit(d, "sha", 32'hBEEFAA44, 1'b0);
      access(d, 0, 1, 32'h6, 2'd2, 32'h55555555);
      lit(d, "sw6", 32'h0, 1'b1);
      access(d, 1, 0, 32'h4, 2'd2, 32'h0);
      lit(d, "lw4", init_w[d][1], 1'b0);
      access(d, 1, 0, 32'h3, 2'd2, 32'h0);
      lit(d, "lw3", 32'h0, 1'b1);
      access(d, 1, 0, 32'(4*DEPTH), 2'd2, 32'h0);
      lit(d, "range", 32'h0, 1'b1);
      access(d, 1, 1, 32'h10, 2'd2, 32'hDEADBEEF);
      lit(d, "conflict", 32'h0, 1'b1);
      access(d, 1, 0, 32'h10, 2'd2, 32'h0);
      lit(d, "lw10", init_w[d][4], 1'b0);
    end

    // reset while a store is stalled in WAIT
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h20; size[1] = 2'd2; sdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    check("midwait_stall_pre", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    check("midwait_stall_drop", {31'd0, stall[1]}, 32'd0);
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    check("midwait_data", ld[1], 32'd0);
    check("midwait_err", {31'd0, err[1]}, 32'd0);
    check("midwait_stall", {31'd0, stall[1]}, 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    last_ld[1] = 32'd0;
    access(1, 1, 0, 32'h20, 2'd2, 32'h0);
    lit(1, "midwait_word", init_w[1][8], 1'b0);

    // randomized traffic, scoreboard-checked
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 300; i++) begin
        int          kind;
        int          am;
        bit          r;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        kind = $urandom_range(0, 19);
        r  = (kind == 0) || (kind < 10);
        w  = (kind == 0) || (kind >= 10);
        sz = 2'($urandom_range(0, 3));
        am = $urandom_range(0, 19);
        if (am < 16) begin
          a = 32'($urandom_range(0, DEPTH*4 - 1));
          if ($urandom_range(0, 3) != 0) begin
            if (r)               a = a & ~32'd3;
            else if (sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
          end
        end else if (am < 19) begin
          a = 32'(DEPTH*4 + $urandom_range(0, 1000));
        end else begin
          a = $urandom;
        end
        access(d, r, w, a, sz, $urandom);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
      end

    repeat (5) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d left expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning added stall cycles per access (0..15).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port mem_read_en  in  1  load request from lsu.
REQ-006 SHALL have port mem_write_en  in  1  store request from lsu.
REQ-007 SHALL have port mem_addr  in  32  byte address from execute_stage.
REQ-008 SHALL have port store_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port store_data  in  32  store value, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-010 SHALL have port mem_wb_load_data  out  32  aligned word read, lsu extracts sub-word.
REQ-011 SHALL have port mem_stall  out  1  pipeline hold request, combinational.
REQ-012 SHALL have port mem_err  out  1  registered error flag for the completed access.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT; request = mem_read_en | mem_write_en.
REQ-014 SHALL, with WAIT_STATES=0, perform the access at the clock edge ending the request cycle, with mem_stall held 0.
REQ-015 SHALL, with WAIT_STATES=N>0, on IDLE+request assert mem_stall, load cnt=N-1, and go to WAIT.
REQ-016 SHALL, in WAIT, assert mem_stall while cnt!=0 and decrement cnt each cycle.
REQ-017 SHALL, in WAIT with cnt==0, deassert mem_stall, perform the access at that edge, and return to IDLE.
REQ-018 SHALL insert exactly N stall cycles per access, with inputs held stable by the pipeline throughout.
REQ-019 SHALL, on a valid read, present mem[addr[31:2]] on mem_wb_load_data in the cycle after the access edge (1-cycle registered latency).
REQ-020 SHALL, on a valid write, set byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all lanes.
REQ-021 SHALL shift store_data into the enabled lanes and leave all other lanes unchanged.
REQ-022 SHALL write exactly once per store regardless of WAIT_STATES.
REQ-023 SHALL flag an error when: word with addr[1:0]!=0; half with addr[0]=1; store_size=11 on a write; addr[31:2]>=DEPTH_WORDS; or mem_read_en and mem_write_en both high.
REQ-024 SHALL, on error, suppress the write, drive mem_wb_load_data to 0, and pulse mem_err for the one cycle after the access edge.
REQ-025 SHALL, for a load, ignore store_size and check alignment of the full-word access only (addr[31:2] range).
REQ-026 SHALL hold mem_wb_load_data at its last value after a write access or an idle cycle.
REQ-027 SHALL ensure mem_err is 0 in every cycle not directly following an erroring access edge.
REQ-028 SHALL serve back-to-back requests in consecutive cycles without a bubble when WAIT_STATES=0.
REQ-029 SHALL, when WAIT_STATES>0, take the request in the cycle after a WAIT->IDLE return as a new access.

Reset
REQ-030 SHALL, while rst=0, force state IDLE, cnt=0, mem_wb_load_data=0, mem_err=0, mem_stall=0.
REQ-031 SHALL, on reset asserted during WAIT, abort the access with no write performed.
REQ-032 SHALL NOT clear memory contents on reset.

Verification
REQ-033 SHALL verify, with WAIT_STATES=0: SW addr 0x8 data 0x11223344, then LW 0x8 -> load_data 0x11223344 one cycle later, mem_stall always 0.
REQ-034 SHALL verify: SB addr 0x9 data 0xAA over word 0x11223344, then LW 0x8 -> 0x1122AA44; SH addr 0xA data 0xBEEF -> 0xBEEFAA44.
REQ-035 SHALL verify misalignment: SW addr 0x6 -> mem_err=1 one cycle, word at 0x4 unchanged; LW addr 0x3 -> load_data 0, mem_err=1.
REQ-036 SHALL verify, with WAIT_STATES=2: LW 0x8 -> mem_stall high exactly 2 cycles, data valid the cycle after stall drops; SW with stall -> single write.
REQ-037 SHALL verify range and conflict errors: LW addr 4*DEPTH_WORDS -> mem_err; read_en and write_en both high -> mem_err, no write.
REQ-038 SHALL verify reset mid-WAIT: rst=0 during a stalled SW -> stall drops, target word unchanged, outputs 0.
